// File: rtl/mc_bus_sched.sv
// mc_bus_sched
// Schedules one bus row between the global buffer and NUM_COL MultiCaster columns.
// A job descriptor (tag, kernel size, initial psum) selects the columns whose ID
// matches the tag. kernel_size ifmap/filter beats are broadcast to those columns.
// Their finished psums are then gathered with round-robin arbitration into one
// output stream. This block only sequences the shared bus; it does no arithmetic.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   cfg_*                 job descriptor handshake (cfg_ready high only when idle)
//   in_*                  ifmap/filter beat stream from the global buffer
//   col_id/col_ready      per-column ID and beat back-pressure
//   col_en                per-column beat strobe
//   col_valid/col_psum    per-column finished psum
//   col_ack               per-column pulse: psum taken
//   bc_*/kernel_size      broadcast data and latched job descriptor
//   out_*                 gathered psum stream with source column index
//   err                   one-cycle pulse when a job is rejected
//   busy                  job in flight or output not yet drained
`timescale 1ns/1ps
module mc_bus_sched #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned NUM_COL    = 4,
    localparam int unsigned CW        = (NUM_COL > 1) ? $clog2(NUM_COL) : 1,
    localparam int unsigned PW        = 2 * DATA_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cfg_valid,
    output logic                    cfg_ready,
    input  logic [CW-1:0]           cfg_tag,
    input  logic [7:0]              cfg_ksize,
    input  logic [PW-1:0]           cfg_ipsum,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_WIDTH-1:0]   in_ifmap,
    input  logic [DATA_WIDTH-1:0]   in_fltr,
    input  logic [NUM_COL*CW-1:0]   col_id,
    input  logic [NUM_COL-1:0]      col_ready,
    output logic [NUM_COL-1:0]      col_en,
    input  logic [NUM_COL-1:0]      col_valid,
    input  logic [NUM_COL*PW-1:0]   col_psum,
    output logic [NUM_COL-1:0]      col_ack,
    output logic [DATA_WIDTH-1:0]   bc_ifmap,
    output logic [DATA_WIDTH-1:0]   bc_fltr,
    output logic [PW-1:0]           bc_psum,
    output logic [CW-1:0]           bc_tag,
    output logic [7:0]              kernel_size,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [PW-1:0]           out_psum,
    output logic [CW-1:0]           out_col,
    output logic                    err,
    output logic                    busy
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_STREAM = 2'd1;
    localparam logic [1:0] ST_GATHER = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [NUM_COL-1:0] mask_q, mask_d;
    logic [NUM_COL-1:0] pending_q, pending_d;
    logic [7:0]         beat_cnt_q, beat_cnt_d;
    logic [CW-1:0]      rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]      tag_q, tag_d;
    logic [7:0]         ksize_q, ksize_d;
    logic [PW-1:0]      ipsum_q, ipsum_d;
    logic               out_valid_q, out_valid_d;
    logic [PW-1:0]      out_psum_q, out_psum_d;
    logic [CW-1:0]      out_col_q, out_col_d;
    logic               err_q, err_d;
    logic [NUM_COL-1:0] col_ack_q, col_ack_d;

    logic [NUM_COL-1:0] id_match;
    logic [PW-1:0]      psum_arr [NUM_COL];
    logic               beat;
    logic               slot_free;
    logic [NUM_COL-1:0] req;
    logic               gnt_found;
    logic [CW-1:0]      gnt_idx;
    logic [CW-1:0]      scan_idx;

    always_comb begin
        for (int unsigned i = 0; i < NUM_COL; i++) begin
            id_match[i] = (col_id[i*CW +: CW] == cfg_tag);
            psum_arr[i] = col_psum[i*PW +: PW];
        end
    end

    // A beat only moves when every targeted column can take it, so all
    // targeted columns always see the same beat sequence.
    assign in_ready  = (state_q == ST_STREAM) && (&(col_ready | ~mask_q));
    assign beat      = in_valid && in_ready;
    assign col_en    = beat ? mask_q : '0;
    assign slot_free = !out_valid_q || out_ready;
    assign req       = pending_q & col_valid;

    // Round-robin: first requesting column at or after rr_ptr, wrapping.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        scan_idx  = '0;
        for (int unsigned k = 0; k < NUM_COL; k++) begin
            scan_idx = CW'((32'(rr_ptr_q) + k) % NUM_COL);
            if (!gnt_found && req[scan_idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = scan_idx;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        mask_d      = mask_q;
        pending_d   = pending_q;
        beat_cnt_d  = beat_cnt_q;
        rr_ptr_d    = rr_ptr_q;
        tag_d       = tag_q;
        ksize_d     = ksize_q;
        ipsum_d     = ipsum_q;
        out_valid_d = out_valid_q && !out_ready;
        out_psum_d  = out_psum_q;
        out_col_d   = out_col_q;
        err_d       = 1'b0;
        col_ack_d   = '0;

        case (state_q)
            ST_IDLE: begin
                if (cfg_valid) begin
                    tag_d   = cfg_tag;
                    ksize_d = cfg_ksize;
                    ipsum_d = cfg_ipsum;
                    mask_d  = id_match;
                    if (cfg_ksize == 8'd0 || id_match == '0) begin
                        err_d = 1'b1;
                    end else begin
                        beat_cnt_d = 8'd0;
                        state_d    = ST_STREAM;
                    end
                end
            end
            ST_STREAM: begin
                if (beat) begin
                    beat_cnt_d = beat_cnt_q + 8'd1;
                    if (beat_cnt_q == ksize_q - 8'd1) begin
                        pending_d = mask_q;
                        state_d   = ST_GATHER;
                    end
                end
            end
            ST_GATHER: begin
                if (slot_free && gnt_found) begin
                    out_valid_d        = 1'b1;
                    out_psum_d         = psum_arr[gnt_idx];
                    out_col_d          = gnt_idx;
                    col_ack_d[gnt_idx] = 1'b1;
                    pending_d[gnt_idx] = 1'b0;
                    rr_ptr_d = (gnt_idx == CW'(NUM_COL - 1)) ? '0 : gnt_idx + 1'b1;
                end
                // Leave as soon as the last grant is issued; its psum may still
                // sit in the output register while we are back in idle.
                if (pending_d == '0) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            mask_q      <= '0;
            pending_q   <= '0;
            beat_cnt_q  <= '0;
            rr_ptr_q    <= '0;
            tag_q       <= '0;
            ksize_q     <= '0;
            ipsum_q     <= '0;
            out_valid_q <= 1'b0;
            out_psum_q  <= '0;
            out_col_q   <= '0;
            err_q       <= 1'b0;
            col_ack_q   <= '0;
        end else begin
            state_q     <= state_d;
            mask_q      <= mask_d;
            pending_q   <= pending_d;
            beat_cnt_q  <= beat_cnt_d;
            rr_ptr_q    <= rr_ptr_d;
            tag_q       <= tag_d;
            ksize_q     <= ksize_d;
            ipsum_q     <= ipsum_d;
            out_valid_q <= out_valid_d;
            out_psum_q  <= out_psum_d;
            out_col_q   <= out_col_d;
            err_q       <= err_d;
            col_ack_q   <= col_ack_d;
        end
    end

    assign cfg_ready   = (state_q == ST_IDLE);
    assign bc_ifmap    = in_ifmap;
    assign bc_fltr     = in_fltr;
    assign bc_psum     = ipsum_q;
    assign bc_tag      = tag_q;
    assign kernel_size = ksize_q;
    assign out_valid   = out_valid_q;
    assign out_psum    = out_psum_q;
    assign out_col     = out_col_q;
    assign err         = err_q;
    assign col_ack     = col_ack_q;
    assign busy        = (state_q != ST_IDLE) || out_valid_q;

endmodule

// File: tb/tb_mc_bus_sched.sv
// tb_mc_bus_sched
// Randomised bench for mc_bus_sched. The stimulus process issues jobs and pushes
// the expected gathered psums (order from the round-robin rule) into a queue; a
// monitor on the falling edge pops and compares every accepted output.
`timescale 1ns/1ps
module tb_mc_bus_sched;

    localparam int DW = 16;
    localparam int NC = 4;
    localparam int CW = 2;
    localparam int PW = 2 * DW;

    logic              clk;
    logic              rst_n;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [CW-1:0]     cfg_tag;
    logic [7:0]        cfg_ksize;
    logic [PW-1:0]     cfg_ipsum;
    logic              in_valid;
    logic              in_ready;
    logic [DW-1:0]     in_ifmap;
    logic [DW-1:0]     in_fltr;
    logic [NC*CW-1:0]  col_id;
    logic [NC-1:0]     col_ready;
    logic [NC-1:0]     col_en;
    logic [NC-1:0]     col_valid;
    logic [NC*PW-1:0]  col_psum;
    logic [NC-1:0]     col_ack;
    logic [DW-1:0]     bc_ifmap;
    logic [DW-1:0]     bc_fltr;
    logic [PW-1:0]     bc_psum;
    logic [CW-1:0]     bc_tag;
    logic [7:0]        kernel_size;
    logic              out_valid;
    logic              out_ready;
    logic [PW-1:0]     out_psum;
    logic [CW-1:0]     out_col;
    logic              err;
    logic              busy;

    mc_bus_sched #(
        .DATA_WIDTH (DW),
        .NUM_COL    (NC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_tag     (cfg_tag),
        .cfg_ksize   (cfg_ksize),
        .cfg_ipsum   (cfg_ipsum),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_ifmap    (in_ifmap),
        .in_fltr     (in_fltr),
        .col_id      (col_id),
        .col_ready   (col_ready),
        .col_en      (col_en),
        .col_valid   (col_valid),
        .col_psum    (col_psum),
        .col_ack     (col_ack),
        .bc_ifmap    (bc_ifmap),
        .bc_fltr     (bc_fltr),
        .bc_psum     (bc_psum),
        .bc_tag      (bc_tag),
        .kernel_size (kernel_size),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_psum    (out_psum),
        .out_col     (out_col),
        .err         (err),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [CW-1:0] col;
        logic [PW-1:0] psum;
    } exp_t;

    exp_t          exp_q[$];
    int            checks = 0;
    int            errors = 0;
    int            rr_model = 0;
    logic [NC-1:0] ack_expect = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Columns drop their psum valid once they see the acknowledge.
    task automatic tick();
        @(posedge clk);
        #1;
        col_valid = col_valid & ~col_ack;
    endtask

    // Output-side monitor: scoreboard pops, hold stability, legal acks.
    logic          prev_hold = 1'b0;
    logic [PW-1:0] prev_psum;
    logic [CW-1:0] prev_col;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                chk("hold_valid", 64'(out_valid), 64'd1);
                chk("hold_psum", 64'(out_psum), 64'(prev_psum));
                chk("hold_col", 64'(out_col), 64'(prev_col));
            end
            for (int i = 0; i < NC; i++) begin
                if (col_ack[i]) begin
                    chk("ack_legal", 64'(ack_expect[i]), 64'd1);
                    ack_expect[i] = 1'b0;
                end
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("out_unexpected", 64'(out_valid), 64'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("out_col", 64'(out_col), 64'(e.col));
                    chk("out_psum", 64'(out_psum), 64'(e.psum));
                end
            end
            prev_hold = out_valid && !out_ready;
            prev_psum = out_psum;
            prev_col  = out_col;
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_bc_psum", 64'(bc_psum), 64'd0);
        chk("rst_bc_tag", 64'(bc_tag), 64'd0);
        chk("rst_ksize", 64'(kernel_size), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_col_ack", 64'(col_ack), 64'd0);
        chk("rst_col_en", 64'(col_en), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_cfg_ready", 64'(cfg_ready), 64'd1);
        exp_q.delete();
        ack_expect = '0;
        rr_model   = 0;
        in_valid   = 1'b0;
        cfg_valid  = 1'b0;
        col_valid  = '0;
        out_ready  = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        tick();
    endtask

    // Issue one job; abort_at>0 resets the block after that many beats.
    task automatic run_job(input logic [NC*CW-1:0] ids, input logic [CW-1:0] tag,
                           input logic [7:0] ks, input logic [PW-1:0] ip,
                           input int abort_at, input bit full_ready);
        logic [NC-1:0] m;
        logic          exp_rdy;
        bit            bad;
        int            sent;
        int            cyc;
        int            n_tgt;
        int            last;
        exp_t          e;

        col_id = ids;
        m      = '0;
        n_tgt  = 0;
        for (int i = 0; i < NC; i++) begin
            if (ids[i*CW +: CW] == tag) begin
                m[i] = 1'b1;
                n_tgt++;
            end
            col_psum[i*PW +: PW] = $urandom;
        end
        bad = (ks == 8'd0) || (m == '0);

        chk("cfg_ready_idle", 64'(cfg_ready), 64'd1);
        cfg_valid = 1'b1;
        cfg_tag   = tag;
        cfg_ksize = ks;
        cfg_ipsum = ip;
        tick();
        cfg_valid = 1'b0;
        #1;
        if (bad) begin
            chk("err_pulse", 64'(err), 64'd1);
            chk("err_cfg_ready", 64'(cfg_ready), 64'd1);
            chk("err_no_en", 64'(col_en), 64'd0);
            tick();
            chk("err_one_cycle", 64'(err), 64'd0);
            return;
        end

        if (abort_at == 0) begin
            last = rr_model;
            for (int k = 0; k < NC; k++) begin
                int c;
                c = (rr_model + k) % NC;
                if (m[c]) begin
                    e.col  = CW'(c);
                    e.psum = col_psum[c*PW +: PW];
                    exp_q.push_back(e);
                    last = c;
                end
            end
            rr_model   = (last + 1) % NC;
            ack_expect = m;
        end

        chk("bc_tag", 64'(bc_tag), 64'(tag));
        chk("bc_psum", 64'(bc_psum), 64'(ip));
        chk("kernel_size", 64'(kernel_size), 64'(ks));
        chk("cfg_ready_busy", 64'(cfg_ready), 64'd0);
        chk("err_quiet", 64'(err), 64'd0);

        sent = 0;
        cyc  = 0;
        in_valid = 1'b0;
        while (sent < int'(ks)) begin
            // An offered beat is held unchanged until it is taken.
            if (!in_valid) begin
                in_valid = ($urandom_range(0, 9) < 7);
                in_ifmap = DW'($urandom);
                in_fltr  = DW'($urandom);
            end
            for (int i = 0; i < NC; i++) col_ready[i] = ($urandom_range(0, 9) < 8);
            #1;
            exp_rdy = &(col_ready | ~m);
            chk("in_ready", 64'(in_ready), 64'(exp_rdy));
            chk("col_en", 64'(col_en), (in_valid && exp_rdy) ? 64'(m) : 64'd0);
            chk("bc_ifmap", 64'(bc_ifmap), 64'(in_ifmap));
            chk("bc_fltr", 64'(bc_fltr), 64'(in_fltr));
            if (in_valid && exp_rdy) sent++;
            tick();
            if (in_valid && exp_rdy) in_valid = 1'b0;
            if (abort_at > 0 && sent == abort_at) begin
                do_reset();
                return;
            end
            cyc++;
            if (cyc > 3000) begin
                chk("stream_timeout", 64'(sent), 64'(ks));
                return;
            end
        end
        in_valid  = 1'b0;
        col_ready = '1;
        #1;
        chk("in_ready_after_stream", 64'(in_ready), 64'd0);
        chk("col_en_after_stream", 64'(col_en), 64'd0);

        col_valid = m;
        out_ready = full_ready ? 1'b1 : 1'($urandom_range(0, 1));
        cyc = 0;
        do begin
            tick();
            cyc++;
            if (!full_ready) out_ready = 1'($urandom_range(0, 1));
        end while (busy && cyc < 500);
        out_ready = 1'b1;
        chk("drain_busy", 64'(busy), 64'd0);
        chk("sb_empty", 64'(exp_q.size()), 64'd0);
        chk("acks_all", 64'(ack_expect), 64'd0);
        if (full_ready) begin
            // One psum per cycle, one cycle of grant latency.
            chk("b2b_cycles", 64'(cyc), 64'(n_tgt + 1));
        end
    endtask

    initial begin
        logic [NC*CW-1:0] ids;
        logic [7:0]       ks;
        logic [CW-1:0]    tag;
        int               c;

        rst_n     = 1'b1;
        cfg_valid = 1'b0;
        cfg_tag   = '0;
        cfg_ksize = '0;
        cfg_ipsum = '0;
        in_valid  = 1'b0;
        in_ifmap  = '0;
        in_fltr   = '0;
        col_id    = '0;
        col_ready = '1;
        col_valid = '0;
        col_psum  = '0;
        out_ready = 1'b1;
        #2;
        do_reset();

        // Identity IDs, single target.
        ids = {2'd3, 2'd2, 2'd1, 2'd0};
        run_job(ids, 2'd2, 8'd3, 32'h10, 0, 1'b1);

        // All columns match: full rotation, then a second job after the wrap.
        do_reset();
        ids = {2'd1, 2'd1, 2'd1, 2'd1};
        run_job(ids, 2'd1, 8'd2, $urandom, 0, 1'b1);
        run_job(ids, 2'd1, 8'd2, $urandom, 0, 1'b1);

        // Rejected jobs.
        ids = {2'd3, 2'd2, 2'd1, 2'd0};
        run_job(ids, 2'd1, 8'd0, $urandom, 0, 1'b1);
        run_job('0, 2'd3, 8'd5, $urandom, 0, 1'b1);

        // Output back-pressure with two targets.
        ids = {2'd2, 2'd0, 2'd2, 2'd1};
        run_job(ids, 2'd2, 8'd3, $urandom, 0, 1'b0);

        // Abort mid-stream, then a fresh job.
        ids = {2'd3, 2'd2, 2'd1, 2'd0};
        run_job(ids, 2'd1, 8'd4, $urandom, 2, 1'b1);
        run_job(ids, 2'd1, 8'd4, $urandom, 0, 1'b1);

        // Maximum kernel size.
        ids = {2'd0, 2'd3, 2'd3, 2'd0};
        run_job(ids, 2'd3, 8'd255, $urandom, 0, 1'b0);

        repeat (40) begin
            for (int i = 0; i < NC; i++) ids[i*CW +: CW] = CW'($urandom_range(0, NC - 1));
            c   = int'($urandom_range(0, NC - 1));
            tag = ($urandom_range(0, 9) < 8) ? ids[c*CW +: CW] : CW'($urandom_range(0, NC - 1));
            ks  = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom_range(1, 8));
            run_job(ids, tag, ks, $urandom, 0, 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors",
                 checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
